sys_row_db: RTL and testbench

Double-buffered systolic MMU row: SYS_COL weight-stationary MAC columns with an activation wavefront moving one column per cycle. Each column holds two weight banks. The active bank computes while the shadow bank is loaded via a sequential write port, and a swap command flips banks without a pipeline bubble. This is the parametrised successor to the single-bank row. It adds a configurable psum width, a per-activation signed/unsigned mode, and a built-in weight-load/swap controller.

---
 rtl/sys_row_pkg.sv | 39 +++
 rtl/sys_row_db_pe.sv | 88 ++++++++
 rtl/sys_row_db.sv | 147 ++++++++++++++
 tb/tb_sys_row_db.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_row_pkg.sv
// Shared types and helpers for the double-buffered systolic row.
package sys_row_pkg;

  // Weight-load controller states.
  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    FULL,
    DRAIN
  } sys_row_ld_e;

  // Tag that travels with each activation: which weight bank it uses and
  // whether its multiply is signed.
  typedef struct packed {
    logic bank;
    logic is_signed;
  } act_tag_t;

  // Widest value ext_val can handle.
  localparam int EXT_MAX_W = 256;

  // Extends the low src_w bits of val to EXT_MAX_W bits.
  // Sign-extends when is_signed is set, zero-extends otherwise.
  // Callers truncate the result to the width they need.
  function automatic logic [EXT_MAX_W-1:0] ext_val(
    input logic [EXT_MAX_W-1:0] val,
    input int                   src_w,
    input logic                 is_signed
  );
    logic [EXT_MAX_W-1:0] keep;
    logic [EXT_MAX_W-1:0] msb;
    logic                 fill;
    keep = ~({EXT_MAX_W{1'b1}} << src_w);
    msb  = {{(EXT_MAX_W-1){1'b0}}, 1'b1} << (src_w - 1);
    fill = is_signed & (|(val & msb));
    return (val & keep) | ({EXT_MAX_W{fill}} & ~keep);
  endfunction

endpackage

// File: rtl/sys_row_db_pe.sv
// One weight-stationary column.
// It holds two weight banks, the activation/tag pass register that feeds
// the next column, and the registered MAC result with its valid flag.
module pe_db
  import sys_row_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_act,
  input  act_tag_t              in_tag,
  input  logic [PSUM_WIDTH-1:0] psum_in,
  input  logic                  w_wr_en,
  input  logic                  w_wr_bank,
  input  logic [DATA_WIDTH-1:0] w_wr_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_act,
  output act_tag_t              out_tag,
  output logic [PSUM_WIDTH-1:0] psum_out
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] w0_q, w0_d;
  logic [DATA_WIDTH-1:0] w1_q, w1_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] act_q, act_d;
  act_tag_t              tag_q, tag_d;
  logic [PSUM_WIDTH-1:0] psum_q, psum_d;

  logic [DATA_WIDTH-1:0] w_sel;
  logic [PROD_W-1:0]     a_x;
  logic [PROD_W-1:0]     w_x;
  logic [PROD_W-1:0]     prod;
  logic [PSUM_WIDTH-1:0] prod_x;

  // Write the addressed bank; the controller only ever targets the shadow bank.
  always_comb begin
    w0_d = w0_q;
    w1_d = w1_q;
    if (w_wr_en) begin
      if (w_wr_bank) w1_d = w_wr_data;
      else           w0_d = w_wr_data;
    end
  end

  // MAC against the bank named in the activation's tag.
  // The activation and tag are then passed on to the next column.
  always_comb begin
    w_sel   = in_tag.bank ? w1_q : w0_q;
    a_x     = PROD_W'(ext_val(EXT_MAX_W'(in_act), DATA_WIDTH, in_tag.is_signed));
    w_x     = PROD_W'(ext_val(EXT_MAX_W'(w_sel), DATA_WIDTH, in_tag.is_signed));
    prod    = a_x * w_x;
    prod_x  = PSUM_WIDTH'(ext_val(EXT_MAX_W'(prod), PROD_W, in_tag.is_signed));
    psum_d  = in_valid ? (psum_in + prod_x) : psum_q;
    valid_d = in_valid;
    act_d   = in_valid ? in_act : act_q;
    tag_d   = in_valid ? in_tag : tag_q;
  end

  // Column state registers; reset clears weights, psum and any in-flight activation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w0_q    <= '0;
      w1_q    <= '0;
      valid_q <= 1'b0;
      act_q   <= '0;
      tag_q   <= '0;
      psum_q  <= '0;
    end else begin
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      valid_q <= valid_d;
      act_q   <= act_d;
      tag_q   <= tag_d;
      psum_q  <= psum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_act   = act_q;
  assign out_tag   = tag_q;
  assign psum_out  = psum_q;

endmodule

// File: rtl/sys_row_db.sv
// Double-buffered systolic MMU row.
// SYS_COL weight-stationary columns share one weight-load/swap controller.
// Activations enter column 0 tagged with the bank that is active at entry,
// then move one column per cycle.
module sys_row_db
  import sys_row_pkg::*;
#(
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  act_valid,
  input  logic [DATA_WIDTH-1:0] act_in,
  input  logic                  act_signed,
  input  logic [PSUM_WIDTH-1:0] psum_in [0:SYS_COL-1],
  output logic [PSUM_WIDTH-1:0] psum_out [0:SYS_COL-1],
  output logic [SYS_COL-1:0]    psum_valid_out,
  input  logic                  w_load_valid,
  input  logic [DATA_WIDTH-1:0] w_load_data,
  output logic                  w_load_ready,
  input  logic                  w_swap,
  output logic                  swap_ack,
  output logic                  active_bank
);

  localparam int                CNT_W    = $clog2(SYS_COL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYS_COL - 1);

  sys_row_ld_e      state_q, state_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             active_bank_q, active_bank_d;
  logic             swap_ack_q, swap_ack_d;
  logic             load_acc;

  act_tag_t              entry_tag;
  logic                  fwd_valid [SYS_COL];
  logic [DATA_WIDTH-1:0] fwd_act   [SYS_COL];
  act_tag_t              fwd_tag   [SYS_COL];

  // Load/swap controller: fill the shadow bank column by column, flip banks on
  // swap, then hold off new writes until the last activation that can still use
  // the old bank has left the final column. That activation is the one sampled
  // on the swap edge, so the drain is a fixed SYS_COL-1 cycles.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    active_bank_d = active_bank_q;
    swap_ack_d    = 1'b0;
    w_load_ready  = (state_q == EMPTY) || (state_q == LOADING);
    load_acc      = w_load_valid && w_load_ready;
    case (state_q)
      EMPTY: begin
        if (load_acc) begin
          load_cnt_d = CNT_W'(1);
          state_d    = LOADING;
        end
      end
      LOADING: begin
        if (load_acc) begin
          load_cnt_d = load_cnt_q + CNT_W'(1);
          if (load_cnt_q == CNT_LAST) state_d = FULL;
        end
      end
      FULL: begin
        if (w_swap) begin
          active_bank_d = ~active_bank_q;
          swap_ack_d    = 1'b1;
          load_cnt_d    = '0;
          drain_cnt_d   = CNT_W'(1);
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == CNT_LAST) begin
          drain_cnt_d = '0;
          state_d     = EMPTY;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Controller registers; after reset bank 0 is active and bank 1 is the shadow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= EMPTY;
      load_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      active_bank_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      active_bank_q <= active_bank_d;
      swap_ack_q    <= swap_ack_d;
    end
  end

  assign entry_tag   = '{bank: active_bank_q, is_signed: act_signed};
  assign active_bank = active_bank_q;
  assign swap_ack    = swap_ack_q;

  for (genvar i = 0; i < SYS_COL; i++) begin : g_col
    logic                  col_valid;
    logic [DATA_WIDTH-1:0] col_act;
    act_tag_t              col_tag;

    if (i == 0) begin : g_head
      assign col_valid = act_valid;
      assign col_act   = act_in;
      assign col_tag   = entry_tag;
    end else begin : g_body
      assign col_valid = fwd_valid[i-1];
      assign col_act   = fwd_act[i-1];
      assign col_tag   = fwd_tag[i-1];
    end

    pe_db #(
      .DATA_WIDTH(DATA_WIDTH),
      .PSUM_WIDTH(PSUM_WIDTH)
    ) u_pe (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (col_valid),
      .in_act    (col_act),
      .in_tag    (col_tag),
      .psum_in   (psum_in[i]),
      .w_wr_en   (load_acc && (load_cnt_q == CNT_W'(i))),
      .w_wr_bank (~active_bank_q),
      .w_wr_data (w_load_data),
      .out_valid (fwd_valid[i]),
      .out_act   (fwd_act[i]),
      .out_tag   (fwd_tag[i]),
      .psum_out  (psum_out[i])
    );

    assign psum_valid_out[i] = fwd_valid[i];
  end

endmodule

// File: tb/tb_sys_row_db.sv
// Directed self-checking bench for sys_row_db with 4 columns, 8-bit data and 16-bit psums.
module tb_sys_row_db;

  localparam int SYS_COL = 4;
  localparam int DW      = 8;
  localparam int PW      = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          act_valid;
  logic [DW-1:0] act_in;
  logic          act_signed;
  logic [PW-1:0] psum_in  [0:SYS_COL-1];
  logic [PW-1:0] psum_out [0:SYS_COL-1];
  logic [SYS_COL-1:0] psum_valid_out;
  logic          w_load_valid;
  logic [DW-1:0] w_load_data;
  logic          w_load_ready;
  logic          w_swap;
  logic          swap_ack;
  logic          active_bank;

  int total = 0;
  int bad   = 0;

  // 10 ns clock.
  always #5 clk = ~clk;

  sys_row_db #(
    .SYS_COL   (SYS_COL),
    .DATA_WIDTH(DW),
    .PSUM_WIDTH(PW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .act_valid     (act_valid),
    .act_in        (act_in),
    .act_signed    (act_signed),
    .psum_in       (psum_in),
    .psum_out      (psum_out),
    .psum_valid_out(psum_valid_out),
    .w_load_valid  (w_load_valid),
    .w_load_data   (w_load_data),
    .w_load_ready  (w_load_ready),
    .w_swap        (w_swap),
    .swap_ack      (swap_ack),
    .active_bank   (active_bank)
  );

  // Advance past the next rising edge and settle 1 ns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] a, input logic s);
    act_valid  = v;
    act_in     = a;
    act_signed = s;
  endtask

  task automatic setPsum(input logic [PW-1:0] v);
    for (int i = 0; i < SYS_COL; i++) psum_in[i] = v;
  endtask

  task automatic loadWeight(input logic [DW-1:0] w);
    w_load_valid = 1'b1;
    w_load_data  = w;
    tick();
    w_load_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bound the run in case something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn         = 1'b0;
    w_load_valid = 1'b0;
    w_load_data  = '0;
    w_swap       = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    setPsum('0);

    // Reset state.
    tick();
    tick();
    checkOutput("rst_valid", 32'(psum_valid_out), 32'h0);
    checkOutput("rst_psum0", 32'(psum_out[0]), 32'h0);
    checkOutput("rst_bank", 32'(active_bank), 32'h0);
    checkOutput("rst_ready", 32'(w_load_ready), 32'h1);
    checkOutput("rst_ack", 32'(swap_ack), 32'h0);
    rstn = 1'b1;

    // Single activation through zero weights: psum passes straight through.
    setPsum(16'd5);
    applyStimulus(1'b1, 8'd3, 1'b0);
    for (int i = 0; i < SYS_COL; i++) begin
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput($sformatf("t1_valid%0d", i), 32'(psum_valid_out), 32'(1) << i);
      checkOutput($sformatf("t1_psum%0d", i), 32'(psum_out[i]), 32'd5);
    end

    // Load 1..4, swap, then act 2 unsigned on the following edge.
    for (int i = 0; i < SYS_COL; i++) loadWeight(8'(i + 1));
    checkOutput("t2_full_ready", 32'(w_load_ready), 32'h0);
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    checkOutput("t2_ack", 32'(swap_ack), 32'h1);
    checkOutput("t2_bank", 32'(active_bank), 32'h1);
    setPsum('0);
    applyStimulus(1'b1, 8'd2, 1'b0);
    for (int i = 0; i < SYS_COL; i++) begin
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput($sformatf("t2_ack_low%0d", i), 32'(swap_ack), 32'h0);
      checkOutput($sformatf("t2_psum%0d", i), 32'(psum_out[i]), 32'(2 * (i + 1)));
      checkOutput($sformatf("t2_valid%0d", i), 32'(psum_valid_out), 32'(1) << i);
      checkOutput($sformatf("t2_ready%0d", i), 32'(w_load_ready), (i >= 2) ? 32'h1 : 32'h0);
    end

    // 0xFF weights: signed and unsigned products, and psum wrap.
    for (int i = 0; i < SYS_COL; i++) loadWeight(8'hFF);
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    checkOutput("t3_ack", 32'(swap_ack), 32'h1);
    checkOutput("t3_bank", 32'(active_bank), 32'h0);
    setPsum('0);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    tick();
    checkOutput("t3_signed0", 32'(psum_out[0]), 32'h0001);
    psum_in[0] = 16'hFFFF;
    applyStimulus(1'b1, 8'hFF, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t3_wrap0", 32'(psum_out[0]), 32'hFE00);
    checkOutput("t3_signed1", 32'(psum_out[1]), 32'h0001);
    tick();
    checkOutput("t3_unsigned1", 32'(psum_out[1]), 32'hFE01);
    checkOutput("t3_signed2", 32'(psum_out[2]), 32'h0001);
    checkOutput("t3_hold0", 32'(psum_out[0]), 32'hFE00);
    checkOutput("t3_valid", 32'(psum_valid_out), 32'h6);
    checkOutput("t3_ready", 32'(w_load_ready), 32'h1);

    // Swap with activations on the swap edge and the edge after it.
    for (int i = 0; i < SYS_COL; i++) loadWeight(8'(i + 5));
    setPsum('0);
    w_swap = 1'b1;
    applyStimulus(1'b1, 8'd1, 1'b0);
    tick();
    w_swap = 1'b0;
    checkOutput("t4_ack", 32'(swap_ack), 32'h1);
    checkOutput("t4_bank", 32'(active_bank), 32'h1);
    checkOutput("t4_old0", 32'(psum_out[0]), 32'hFF);
    checkOutput("t4_ready_s", 32'(w_load_ready), 32'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    w_load_valid = 1'b1;
    w_load_data  = 8'h77;
    checkOutput("t4_new0", 32'(psum_out[0]), 32'h05);
    checkOutput("t4_old1", 32'(psum_out[1]), 32'hFF);
    checkOutput("t4_ready_s1", 32'(w_load_ready), 32'h0);
    tick();
    w_load_valid = 1'b0;
    checkOutput("t4_new1", 32'(psum_out[1]), 32'h06);
    checkOutput("t4_old2", 32'(psum_out[2]), 32'hFF);
    checkOutput("t4_ready_s2", 32'(w_load_ready), 32'h0);
    tick();
    checkOutput("t4_new2", 32'(psum_out[2]), 32'h07);
    checkOutput("t4_old3", 32'(psum_out[3]), 32'hFF);
    checkOutput("t4_ready_s3", 32'(w_load_ready), 32'h1);
    tick();
    checkOutput("t4_new3", 32'(psum_out[3]), 32'h08);

    // Swap requests in EMPTY and LOADING are ignored.
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    checkOutput("t5_empty_ack", 32'(swap_ack), 32'h0);
    checkOutput("t5_empty_bank", 32'(active_bank), 32'h1);
    loadWeight(8'h11);
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    checkOutput("t5_loading_ack", 32'(swap_ack), 32'h0);
    checkOutput("t5_loading_bank", 32'(active_bank), 32'h1);
    loadWeight(8'h22);
    loadWeight(8'h33);
    checkOutput("t5_partial_ready", 32'(w_load_ready), 32'h1);
    loadWeight(8'h44);
    checkOutput("t5_full_ready", 32'(w_load_ready), 32'h0);

    // Swap and load together in FULL: the swap is taken and the load is dropped.
    w_swap       = 1'b1;
    w_load_valid = 1'b1;
    w_load_data  = 8'h99;
    tick();
    w_swap       = 1'b0;
    w_load_valid = 1'b0;
    checkOutput("t5_full_ack", 32'(swap_ack), 32'h1);
    checkOutput("t5_full_bank", 32'(active_bank), 32'h0);
    checkOutput("t5_drain_ready", 32'(w_load_ready), 32'h0);
    setPsum(16'h0100);
    applyStimulus(1'b1, 8'd1, 1'b0);
    for (int i = 0; i < SYS_COL; i++) begin
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput($sformatf("t5_psum%0d", i), 32'(psum_out[i]), 32'h100 + 32'(8'h11 * (i + 1)));
    end

    // Reset in the middle of a load, with an activation being presented.
    loadWeight(8'h0A);
    loadWeight(8'h0B);
    applyStimulus(1'b1, 8'd5, 1'b0);
    rstn = 1'b0;
    #2;
    checkOutput("t6_valid", 32'(psum_valid_out), 32'h0);
    checkOutput("t6_psum0", 32'(psum_out[0]), 32'h0);
    checkOutput("t6_psum3", 32'(psum_out[3]), 32'h0);
    checkOutput("t6_bank", 32'(active_bank), 32'h0);
    checkOutput("t6_ready", 32'(w_load_ready), 32'h1);
    checkOutput("t6_ack", 32'(swap_ack), 32'h0);
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    rstn = 1'b1;

    // A full reload after reset starts again from column 0.
    loadWeight(8'd2);
    loadWeight(8'd3);
    loadWeight(8'd4);
    checkOutput("t6_reload_ready", 32'(w_load_ready), 32'h1);
    loadWeight(8'd5);
    checkOutput("t6_reload_full", 32'(w_load_ready), 32'h0);
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    checkOutput("t6_swap_ack", 32'(swap_ack), 32'h1);
    checkOutput("t6_swap_bank", 32'(active_bank), 32'h1);
    setPsum('0);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < SYS_COL; i++) begin
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput($sformatf("t6_psum%0d", i), 32'(psum_out[i]), 32'hFFFE - 32'(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
